// File: rtl/burst_reader_pkg.sv
// Shared types and helpers for the PSRAM burst readback path.
package burst_reader_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    FULL      = 2'd2
  } burst_reader_state_e;

  // Each 64-bit beat carries eight bytes.
  function automatic int burst_bytes(input int beats);
    return 8 * beats;
  endfunction

endpackage

// File: rtl/burst_bus_if.sv
// Burst command bus shared by the PSRAM controller and its arbiter masters.
interface burst_bus_if;
  logic [20:0] addr;
  logic        cmd;
  logic        cmd_en;
  logic [63:0] wr_data;
  logic [7:0]  data_mask;
  logic        ready;
  logic [63:0] rd_data;
  logic        rd_data_valid;

  modport master (
    output addr, cmd, cmd_en, wr_data, data_mask,
    input  ready, rd_data, rd_data_valid
  );

  modport slave (
    input  addr, cmd, cmd_en, wr_data, data_mask,
    output ready, rd_data, rd_data_valid
  );
endinterface

// File: rtl/burst_byte_buffer.sv
// Local copy of one read burst: whole-beat write port, byte-wide read mux.
module burst_byte_buffer
  import burst_reader_pkg::*;
#(
  parameter int BEATS = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   wr_en,
  input  logic [$clog2(BEATS)-1:0]               wr_beat,
  input  logic [63:0]                            wr_data,
  input  logic [$clog2(burst_bytes(BEATS))-1:0]  rd_idx,
  output logic [7:0]                             rd_byte
);

  localparam int IDX_W = $clog2(burst_bytes(BEATS));

  logic [63:0] beats_r [BEATS];

  // Beat storage, cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BEATS; i++) begin
        beats_r[i] <= 64'd0;
      end
    end else if (wr_en) begin
      beats_r[wr_beat] <= wr_data;
    end
  end

  // Byte k lives in beat k/8, least significant byte first.
  always_comb begin
    rd_byte = beats_r[rd_idx[IDX_W-1:3]][{rd_idx[2:0], 3'b000} +: 8];
  end

endmodule

// File: rtl/burst_reader.sv
// Debug-side PSRAM reader: prefetches one burst and hands it out a byte per pop.
module burst_reader
  import burst_reader_pkg::*;
#(
  parameter int BEATS_PER_BURST = 4,
  parameter int ADDR_STEP       = 16,
  parameter int TIMEOUT_CYCLES  = 63
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pop,
  output logic [7:0]       data,
  output logic             data_valid,
  output logic             underflow,
  output logic             timeout,
  burst_bus_if.master      mem
);

  localparam int BURST_BYTES = burst_bytes(BEATS_PER_BURST);
  localparam int IDX_W       = $clog2(BURST_BYTES);
  localparam int BEAT_W      = $clog2(BEATS_PER_BURST);
  localparam int TMR_W       = $clog2(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE      = IDLE;
  localparam logic [1:0] S_WAIT_DATA = WAIT_DATA;
  localparam logic [1:0] S_FULL      = FULL;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BURST_BYTES - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_BURST - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]        state_r;
  logic [20:0]       rd_addr_r;
  logic [20:0]       addr_r;
  logic              cmd_en_r;
  logic [BEAT_W-1:0] beat_cnt_r;
  logic [TMR_W-1:0]  timer_r;
  logic [IDX_W-1:0]  idx_r;
  logic [7:0]        data_r;
  logic              data_valid_r;
  logic              underflow_r;
  logic              timeout_r;

  logic              wr_en_s;
  logic              last_beat_s;
  logic [IDX_W-1:0]  rd_idx_s;
  logic [7:0]        rd_byte_s;

  assign wr_en_s     = (state_r == S_WAIT_DATA) && mem.rd_data_valid;
  assign last_beat_s = wr_en_s && (beat_cnt_r == LAST_BEAT);

  // The mux looks one byte ahead so data can be a plain register.
  always_comb begin
    if (state_r == S_FULL) begin
      rd_idx_s = idx_r + IDX_W'(1);
    end else begin
      rd_idx_s = {IDX_W{1'b0}};
    end
  end

  burst_byte_buffer #(
    .BEATS (BEATS_PER_BURST)
  ) u_buffer (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en_s),
    .wr_beat (beat_cnt_r),
    .wr_data (mem.rd_data),
    .rd_idx  (rd_idx_s),
    .rd_byte (rd_byte_s)
  );

  // Command issue, beat collection, timeout and byte hand-out.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_IDLE;
      rd_addr_r    <= 21'd0;
      addr_r       <= 21'd0;
      cmd_en_r     <= 1'b0;
      beat_cnt_r   <= {BEAT_W{1'b0}};
      timer_r      <= {TMR_W{1'b0}};
      idx_r        <= {IDX_W{1'b0}};
      data_r       <= 8'd0;
      data_valid_r <= 1'b0;
      underflow_r  <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      cmd_en_r <= 1'b0;
      if (pop && !data_valid_r) begin
        underflow_r <= 1'b1;
      end
      case (state_r)
        S_IDLE: begin
          if (mem.ready) begin
            cmd_en_r   <= 1'b1;
            addr_r     <= rd_addr_r;
            rd_addr_r  <= rd_addr_r + 21'(ADDR_STEP);
            beat_cnt_r <= {BEAT_W{1'b0}};
            timer_r    <= {TMR_W{1'b0}};
            state_r    <= S_WAIT_DATA;
          end
        end
        S_WAIT_DATA: begin
          timer_r <= timer_r + TMR_W'(1);
          if (wr_en_s) begin
            beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
          end
          if (last_beat_s) begin
            state_r      <= S_FULL;
            idx_r        <= {IDX_W{1'b0}};
            data_r       <= rd_byte_s;
            data_valid_r <= 1'b1;
          end else if (timer_r == TMR_LAST) begin
            // Address stays advanced; the lost burst is simply skipped.
            timeout_r <= 1'b1;
            state_r   <= S_IDLE;
          end
        end
        S_FULL: begin
          if (pop) begin
            if (idx_r == LAST_IDX) begin
              state_r      <= S_IDLE;
              idx_r        <= {IDX_W{1'b0}};
              data_valid_r <= 1'b0;
            end else begin
              idx_r  <= idx_r + IDX_W'(1);
              data_r <= rd_byte_s;
            end
          end
        end
        default: begin
          state_r      <= S_IDLE;
          data_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign data       = data_r;
  assign data_valid = data_valid_r;
  assign underflow  = underflow_r;
  assign timeout    = timeout_r;

  assign mem.addr      = addr_r;
  assign mem.cmd       = 1'b0;
  assign mem.cmd_en    = cmd_en_r;
  assign mem.wr_data   = 64'd0;
  assign mem.data_mask = 8'd0;

endmodule

// File: tb/tb_burst_reader.sv
// Directed bench for burst_reader with a simple PSRAM read model on the bus.
module tb_burst_reader;

  logic       clk;
  logic       reset;
  logic       pop;
  logic [7:0] data;
  logic       data_valid;
  logic       underflow;
  logic       timeout;

  burst_bus_if bus ();

  burst_reader dut (
    .clk        (clk),
    .reset      (reset),
    .pop        (pop),
    .data       (data),
    .data_valid (data_valid),
    .underflow  (underflow),
    .timeout    (timeout),
    .mem        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // memory model state
  logic [20:0] cmd_addrs[$];
  int          cmd_count   = 0;
  int          beats_limit = 4;
  int          sent        = 0;
  int          limit       = 0;
  int          gap         = 0;
  int          hold        = 0;
  logic [7:0]  cur_base    = 8'd0;
  logic [7:0]  next_base   = 8'd0;

  typedef struct {
    int         pops;
    logic [7:0] exp_data;
    logic       exp_valid;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [63:0] beat(input logic [7:0] base, input int j);
    logic [63:0] b;
    for (int i = 0; i < 8; i++) begin
      b[8*i +: 8] = base + 8'(8*j + i);
    end
    return b;
  endfunction

  // Read model: ready drops for 20 cycles per command, beats follow after 3 cycles.
  initial begin
    bus.ready         = 1'b1;
    bus.rd_data       = 64'd0;
    bus.rd_data_valid = 1'b0;
    forever begin
      @(negedge clk);
      bus.rd_data_valid = 1'b0;
      if (bus.cmd_en === 1'b1) begin
        chk("cmd_while_ready", {63'd0, bus.ready}, 64'd1);
        chk("cmd_is_read", {55'd0, bus.cmd, bus.data_mask}, 64'd0);
        chk("cmd_wr_data", bus.wr_data, 64'd0);
        cmd_addrs.push_back(bus.addr);
        cmd_count++;
        cur_base  = next_base;
        next_base = next_base + 8'd32;
        sent      = 0;
        limit     = beats_limit;
        gap       = 3;
        hold      = 20;
        bus.ready = 1'b0;
      end else begin
        if (hold > 0) begin
          hold--;
          if (hold == 0) bus.ready = 1'b1;
        end
        if (gap > 0) begin
          gap--;
        end else if (sent < limit) begin
          bus.rd_data       = beat(cur_base, sent);
          bus.rd_data_valid = 1'b1;
          sent++;
        end
      end
    end
  end

  task automatic wait_cmd(input int n, input int budget);
    for (int i = 0; i < budget && cmd_count < n; i++) tick();
    chk("cmd_seen", {63'd0, cmd_count >= n}, 64'd1);
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !data_valid; i++) tick();
    chk("valid_reached", {63'd0, data_valid}, 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && data_valid; i++) begin
      pop = 1'b1;
      tick();
      pop = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0,  8'h00, 1'b1};
    tbl[1] = '{1,  8'h01, 1'b1};
    tbl[2] = '{7,  8'h07, 1'b1};
    tbl[3] = '{8,  8'h08, 1'b1};
    tbl[4] = '{15, 8'h0F, 1'b1};
    tbl[5] = '{16, 8'h10, 1'b1};
    tbl[6] = '{24, 8'h18, 1'b1};
    tbl[7] = '{31, 8'h1F, 1'b1};
    tbl[8] = '{32, 8'h00, 1'b0};

    reset = 1'b1;
    pop   = 1'b0;
    repeat (3) tick();
    chk("rst_data", {56'd0, data}, 64'd0);
    chk("rst_valid", {63'd0, data_valid}, 64'd0);
    chk("rst_underflow", {63'd0, underflow}, 64'd0);
    chk("rst_timeout", {63'd0, timeout}, 64'd0);
    chk("rst_cmd_en", {63'd0, bus.cmd_en}, 64'd0);
    chk("rst_addr", {43'd0, bus.addr}, 64'd0);
    chk("rst_cmd", {63'd0, bus.cmd}, 64'd0);
    chk("rst_wr_data", bus.wr_data, 64'd0);
    chk("rst_mask", {56'd0, bus.data_mask}, 64'd0);
    reset = 1'b0;

    // first burst; pop during WAIT_DATA must only flag underflow
    wait_cmd(1, 10);
    chk("addr_burst1", {43'd0, cmd_addrs[0]}, 64'd0);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("underflow_set", {63'd0, underflow}, 64'd1);
    wait_valid(20);

    begin
      int popped = 0;
      for (int i = 0; i < 9; i++) begin
        while (popped < tbl[i].pops) begin
          pop = 1'b1;
          tick();
          pop = 1'b0;
          popped++;
        end
        chk($sformatf("tbl%0d_valid", i), {63'd0, data_valid}, {63'd0, tbl[i].exp_valid});
        if (tbl[i].exp_valid) begin
          chk($sformatf("tbl%0d_data", i), {56'd0, data}, {56'd0, tbl[i].exp_data});
        end
      end
    end
    chk("single_cmd", cmd_count, 64'd1);

    // bursts 2 and 3 at stepped addresses
    wait_cmd(2, 10);
    chk("addr_burst2", {43'd0, cmd_addrs[1]}, 64'd16);
    wait_valid(20);
    chk("burst2_first", {56'd0, data}, 64'h20);
    drain();
    chk("underflow_sticky", {63'd0, underflow}, 64'd1);
    wait_cmd(3, 10);
    chk("addr_burst3", {43'd0, cmd_addrs[2]}, 64'd32);
    wait_valid(20);
    beats_limit = 3;
    drain();

    // burst 4 returns only three beats
    wait_cmd(4, 10);
    beats_limit = 4;
    chk("addr_burst4", {43'd0, cmd_addrs[3]}, 64'd48);
    repeat (62) tick();
    chk("timeout_c62", {63'd0, timeout}, 64'd0);
    tick();
    chk("timeout_c63", {63'd0, timeout}, 64'd1);
    chk("timeout_no_valid", {63'd0, data_valid}, 64'd0);
    wait_cmd(5, 10);
    chk("addr_burst5", {43'd0, cmd_addrs[4]}, 64'd64);
    wait_valid(20);
    chk("burst5_first", {56'd0, data}, 64'h80);

    // jump the read pointer to the top of the address space
    force dut.rd_addr_r = 21'h1FFFF0;
    tick();
    release dut.rd_addr_r;
    drain();
    wait_cmd(6, 10);
    chk("addr_top", {43'd0, cmd_addrs[5]}, 64'h1FFFF0);
    wait_valid(20);
    drain();
    wait_cmd(7, 10);
    chk("addr_wrap", {43'd0, cmd_addrs[6]}, 64'd0);
    chk("timeout_sticky", {63'd0, timeout}, 64'd1);

    // reset after two beats of burst 7, with pop in the same cycle
    for (int i = 0; i < 20 && sent < 2; i++) tick();
    chk("two_beats_sent", sent, 64'd2);
    tick();
    reset = 1'b1;
    pop   = 1'b1;
    tick();
    reset = 1'b0;
    pop   = 1'b0;
    chk("mid_rst_underflow", {63'd0, underflow}, 64'd0);
    chk("mid_rst_timeout", {63'd0, timeout}, 64'd0);
    chk("mid_rst_valid", {63'd0, data_valid}, 64'd0);
    chk("mid_rst_addr", {43'd0, bus.addr}, 64'd0);
    wait_cmd(8, 40);
    chk("addr_after_rst", {43'd0, cmd_addrs[7]}, 64'd0);
    chk("valid_after_rst", {63'd0, data_valid}, 64'd0);
    wait_valid(20);
    chk("fresh_byte0", {56'd0, data}, 64'hE0);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("fresh_byte1", {56'd0, data}, 64'hE1);
    chk("no_underflow_after_rst", {63'd0, underflow}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
